fma_arbiter: RTL and testbench
==============================

# fma_arbiter

Round-robin arbiter and result router that shares one `fpu_fma_pipeline` instance between `NUM_REQ` requesters. It accepts FMA operand triples over per-requester valid/ready handshakes and issues at most one per cycle into the pipeline. Because the pipeline carries no tag and has no backpressure, the arbiter keeps an in-order tag FIFO and routes each `F_out` back to its originating requester. It also caps in-flight operations and supports a drain sequence for quiescing the unit.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester-id width; must equal clog2(`NUM_REQ`).
- `DEPTH`, 8: maximum in-flight operations and tag FIFO depth; power of two, at least pipeline latency + 1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester operand valid.
- `req_ready`  out  NUM_REQ: per-requester accept; at most one bit high.
- `req_a`, `req_b`, `req_c`  in  32*NUM_REQ each: flattened IEEE-754 single operands; requester i uses bits [32i+31:32i].
- `fma_valid_in`  out  1: to pipeline `valid_in`.
- `fma_a`, `fma_b`, `fma_c`  out  32 each: to pipeline `A_in`, `B_in`, `C_in`.
- `fma_valid_out`  in  1: from pipeline `valid_out`.
- `fma_f`  in  32: from pipeline `F_out`.
- `rsp_valid`  out  NUM_REQ: one-hot, single-cycle result strobe.
- `rsp_data`  out  32: result, valid with any `rsp_valid` bit.
- `drain_req`  in  1: level; stop accepting new requests.
- `drain_done`  out  1: high in DRAINED state.
- `inflight`  out  clog2(DEPTH)+1: current in-flight count.
- `err_orphan`  out  1: sticky; a result arrived with the tag FIFO empty.

## Operation
- FSM states:
  - RUN: grants enabled. Go to DRAIN when `drain_req`=1.
  - DRAIN: grants blocked. Go to DRAINED when `inflight`==0 and `fma_valid_in`==0.
  - DRAINED: grants blocked; `drain_done`=1. Go to RUN when `drain_req`=0.
  - If `drain_req` drops while in DRAIN, return to RUN.
- Grant:
  - In RUN, when `inflight` < DEPTH, grant the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap.
  - Drive `req_ready[g]`=1 combinationally for the granted requester only.
  - Handshake occurs when `req_valid[g]` & `req_ready[g]`; `rr_ptr` then moves to g+1 mod NUM_REQ.
  - With no handshake, `rr_ptr` holds.
- Issue:
  - On a handshake, register the operands into `fma_a/b/c` and assert `fma_valid_in` for exactly the next cycle.
  - Push g into the tag FIFO in the same cycle.
  - When not issuing, `fma_a/b/c` hold their last values.
- Return:
  - On `fma_valid_out`, pop the FIFO head h, drive `rsp_valid[h]`=1 and `rsp_data`=`fma_f` in the next cycle (registered).
  - If `fma_valid_out` arrives with the FIFO empty: set `err_orphan`, drop the result, leave `inflight` unchanged.
- Count:
  - `inflight` +1 on handshake, −1 on a valid pop.
  - Handshake and pop in the same cycle: count unchanged.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
- Requesters must accept `rsp_valid` unconditionally; there is no response backpressure.

## Timing
- Reset values:
  - `req_ready`=0, `fma_valid_in`=0, `fma_a/b/c`=0.
  - `rsp_valid`=0, `rsp_data`=0.
  - `drain_done`=0, `inflight`=0, `err_orphan`=0.
  - FSM=RUN, `rr_ptr`=0, FIFO empty.
- Latency:
  - Handshake at edge N → `fma_valid_in` high during cycle N+1.
  - `fma_valid_out` at edge M → `rsp_valid` during cycle M+1.
  - End-to-end = pipeline latency + 2.
- Throughput: one issue per cycle, sustained while `inflight` < DEPTH.
- Reset asserted mid-operation clears all state immediately. The pipeline shares `rst_n`, so no stale results are expected; any stale result appearing afterward sets `err_orphan`.

## Structure
- Shared package `fma_pkg`: FP32 width constant, requester-id type, FSM state enum (RUN/DRAIN/DRAINED).
- Sub-module `fma_tag_fifo`: synchronous FIFO, width `ID_W`, depth `DEPTH`, with push/pop/full/empty/count.
- The arbiter top instantiates `fma_tag_fifo` only. `fpu_fma_pipeline` is instantiated beside it at the next level up.

## Test plan
- Single request: requester 0 sends A=0x3FC00000, B=0x40200000, C=0x40400000 → `rsp_valid`=4'b0001, `rsp_data`=0x40D80000 (6.75); `inflight` returns to 0.
- Contention: requesters 0–3 all valid at once → grants issue in order 0,1,2,3 over consecutive cycles. Requester 1 sends 0x41200000, 0xBF000000, 0x42C80000 → its response strobe returns 0x42BE0000 (95.0), in issue order.
- Fairness: requesters 0 and 2 held valid continuously → grants alternate 0,2,0,2.
- Credit limit: DEPTH=8, all requesters valid, pipeline output stalled by the bench → exactly 8 issues, then `req_ready`=0. One `fma_valid_out` → one further grant.
- Drain: assert `drain_req` with 3 in flight → no new grants; `drain_done` rises the cycle after the third response. Deassert → RUN, grants resume. Requester 3 then sends 0x3E800000 ×3 → 0x3EA00000 (0.3125).
- Orphan and reset: inject `fma_valid_out` with the FIFO empty → `err_orphan`=1 and no `rsp_valid`. Pulse `rst_n` low mid-stream → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/fma_pkg.sv
// fma_pkg: definitions shared by the FMA arbiter slice.
//   FP_W         width of an IEEE-754 single operand/result
//   MAX_ID_W     widest requester id the arbiter supports (8 requesters)
//   req_id_t     requester-id type at its widest
//   fsm_state_t  arbiter operating modes (RUN / DRAIN / DRAINED)
//   rr_next()    round-robin successor of a requester index
package fma_pkg;

    localparam int FP_W     = 32;
    localparam int MAX_ID_W = 3;

    typedef logic [MAX_ID_W-1:0] req_id_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } fsm_state_t;

    // Next requester after cur, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/fma_tag_fifo.sv
// fma_tag_fifo: in-order FIFO of requester ids for operations in the FMA pipeline.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (accepted when not full, or when popping too)
//   push_data    requester id of the operation just issued
//   pop          remove the head entry (ignored while empty)
//   head         oldest entry, valid while !empty
//   full, empty  occupancy flags
//   count        number of entries held (0..DEPTH)
module fma_tag_fifo
    import fma_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; only the pointers and
    // count define which entries are meaningful, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fma_arbiter.sv
// fma_arbiter: shares one untagged, non-stalling FMA pipeline among NUM_REQ
// requesters. Round-robin grant, one issue per cycle, in-order result routing
// through a tag FIFO, in-flight cap of DEPTH and a drain/quiesce sequence.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a/b/c             flattened operands, requester i at [32i+31:32i]
//   fma_valid_in, fma_a/b/c   registered issue to the pipeline
//   fma_valid_out, fma_f  pipeline result
//   rsp_valid, rsp_data   registered one-hot result strobe and data
//   drain_req/drain_done  quiesce request (level) and completion
//   inflight              operations issued but not yet returned
//   err_orphan            sticky: a result arrived with nothing in flight
module fma_arbiter
    import fma_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [FP_W*NUM_REQ-1:0]   req_a,
    input  logic [FP_W*NUM_REQ-1:0]   req_b,
    input  logic [FP_W*NUM_REQ-1:0]   req_c,
    output logic                      fma_valid_in,
    output logic [FP_W-1:0]           fma_a,
    output logic [FP_W-1:0]           fma_b,
    output logic [FP_W-1:0]           fma_c,
    input  logic                      fma_valid_out,
    input  logic [FP_W-1:0]           fma_f,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [FP_W-1:0]           rsp_data,
    input  logic                      drain_req,
    output logic                      drain_done,
    output logic [$clog2(DEPTH):0]    inflight,
    output logic                      err_orphan
);

    fsm_state_t      state;
    fsm_state_t      state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] head_id;
    logic            grant_valid;
    logic            handshake;
    logic            pop_valid;
    logic            fifo_full;
    logic            fifo_empty;
    int              sel_base;

    // ------------------------------------------------------------------
    // Grant: first valid requester at or after rr_ptr, with wrap. Held off
    // during reset so req_ready reads zero while rst_n is low.
    // ------------------------------------------------------------------
    always_comb begin : grant_search
        logic [ID_W-1:0] cand;
        // NOTE: every variable gets a default before any branch so this block
        // stays purely combinational (no latch for paths that skip an assignment).
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (rst_n && state == ST_RUN && !fifo_full) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) req_ready[grant_idx] = 1'b1;
    end

    assign handshake = |(req_valid & req_ready);
    assign pop_valid = fma_valid_out && !fifo_empty;
    assign sel_base  = int'(grant_idx) * FP_W;

    // ------------------------------------------------------------------
    // Mode control. A falling drain_req always returns to RUN; DRAINED is
    // reached only once nothing is in flight and nothing is being issued.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (drain_req) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req)                           state_next = ST_RUN;
                else if (inflight == '0 && !fma_valid_in) state_next = ST_DRAINED;
            end
            ST_DRAINED: if (!drain_req) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    assign drain_done = (state == ST_DRAINED);

    // ------------------------------------------------------------------
    // Issue, return routing and sticky error.
    // ------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            rr_ptr       <= '0;
            fma_valid_in <= 1'b0;
            fma_a        <= '0;
            fma_b        <= '0;
            fma_c        <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            err_orphan   <= 1'b0;
        end else begin
            state        <= state_next;
            fma_valid_in <= handshake;
            if (handshake) begin
                fma_a  <= req_a[sel_base +: FP_W];
                fma_b  <= req_b[sel_base +: FP_W];
                fma_c  <= req_c[sel_base +: FP_W];
                rr_ptr <= ID_W'(rr_next(int'(grant_idx), NUM_REQ));
            end
            // The strobe is one cycle wide; the data holds until the next result.
            rsp_valid <= '0;
            if (pop_valid) begin
                rsp_valid[head_id] <= 1'b1;
                rsp_data           <= fma_f;
            end
            // A result with no matching tag is dropped and flagged.
            if (fma_valid_out && fifo_empty) err_orphan <= 1'b1;
        end
    end

    // The FIFO occupancy is exactly the in-flight count: one push per issue,
    // one pop per routed result.
    fma_tag_fifo #(
        .W     (ID_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (handshake),
        .push_data (grant_idx),
        .pop       (fma_valid_out),
        .head      (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (inflight)
    );

endmodule

// File: tb/tb_fma_arbiter.sv
`timescale 1ns/1ps
// tb_fma_arbiter: directed bench for fma_arbiter. A stub plays the FMA
// pipeline (fixed latency, optional output stall, orphan injection); a
// queue-based model predicts every DUT output each cycle, and directed
// scenarios pin grant order, routing, credit limit, drain and reset.
module tb_fma_arbiter;
    import fma_pkg::*;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a = '0, req_b = '0, req_c = '0;
    logic              fma_valid_in;
    logic [31:0]       fma_a, fma_b, fma_c;
    logic              fma_valid_out = 1'b0;
    logic [31:0]       fma_f = '0;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic              drain_req = 1'b0;
    logic              drain_done;
    logic [CW-1:0]     inflight;
    logic              err_orphan;

    always #5 clk = ~clk;

    fma_arbiter #(.NUM_REQ(N), .ID_W(IDW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fma_valid_in(fma_valid_in), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_valid_out(fma_valid_out), .fma_f(fma_f),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Known FMA results; anything else gets an arbitrary but operand-dependent value.
    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        case ({a, b, c})
            {32'h3FC00000, 32'h40200000, 32'h40400000}: return 32'h40D80000;
            {32'h41200000, 32'hBF000000, 32'h42C80000}: return 32'h42BE0000;
            {32'h3E800000, 32'h3E800000, 32'h3E800000}: return 32'h3EA00000;
            default: return a ^ {b[15:0], b[31:16]} ^ c ^ 32'h5A5A0000;
        endcase
    endfunction

    // ---------------- pipeline stub ----------------
    typedef struct { logic [31:0] data; int due; } pipe_ent_t;
    pipe_ent_t pipe_q[$];
    int  pcyc = 0;
    bit  stall = 1'b0;
    bit  release_one = 1'b0;
    bit  inject_orphan = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            pcyc++;
            if (!rst_n) begin
                pipe_q.delete();
                fma_valid_out = 1'b0;
            end else begin
                if (fma_valid_in)
                    pipe_q.push_back('{data: fma_ref(fma_a, fma_b, fma_c), due: pcyc + LAT});
                fma_valid_out = 1'b0;
                if (inject_orphan) begin
                    fma_valid_out = 1'b1;
                    fma_f         = 32'hDEADBEEF;
                    inject_orphan = 1'b0;
                end else if (pipe_q.size() > 0 && pipe_q[0].due <= pcyc && (!stall || release_one)) begin
                    fma_valid_out = 1'b1;
                    fma_f         = pipe_q[0].data;
                    void'(pipe_q.pop_front());
                    release_one   = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int           m_mode;
    int           m_ptr;
    int           m_tags[$];
    logic         m_fvin;
    logic [31:0]  m_fa, m_fb, m_fc, m_rdata;
    logic [N-1:0] m_rvalid;
    logic         m_orphan;

    task automatic model_reset();
        m_mode = M_RUN; m_ptr = 0; m_tags.delete();
        m_fvin = 1'b0; m_fa = '0; m_fb = '0; m_fc = '0;
        m_rdata = '0; m_rvalid = '0; m_orphan = 1'b0;
    endtask

    initial begin
        int g, idx, h;
        logic [N-1:0] e_ready;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            g = -1;
            if (rst_n && m_mode == M_RUN && m_tags.size() < DEPTH)
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;
            check("req_ready",    32'(req_ready),    32'(e_ready));
            check("fma_valid_in", 32'(fma_valid_in), 32'(m_fvin));
            check("fma_a",        fma_a,             m_fa);
            check("fma_b",        fma_b,             m_fb);
            check("fma_c",        fma_c,             m_fc);
            check("rsp_valid",    32'(rsp_valid),    32'(m_rvalid));
            check("rsp_data",     rsp_data,          m_rdata);
            check("drain_done",   32'(drain_done),   32'(m_mode == M_DRAINED));
            check("inflight",     32'(inflight),     32'(m_tags.size()));
            check("err_orphan",   32'(err_orphan),   32'(m_orphan));
            if (rst_n) begin
                case (m_mode)
                    M_RUN:     if (drain_req) m_mode = M_DRAIN;
                    M_DRAIN:   if (!drain_req) m_mode = M_RUN;
                               else if (m_tags.size() == 0 && !m_fvin) m_mode = M_DRAINED;
                    default:   if (!drain_req) m_mode = M_RUN;
                endcase
                m_rvalid = '0;
                if (fma_valid_out) begin
                    if (m_tags.size() > 0) begin
                        h = m_tags.pop_front();
                        m_rvalid[h] = 1'b1;
                        m_rdata     = fma_f;
                    end else begin
                        m_orphan = 1'b1;
                    end
                end
                m_fvin = (g >= 0);
                if (g >= 0) begin
                    m_fa = req_a[g*32 +: 32];
                    m_fb = req_b[g*32 +: 32];
                    m_fc = req_c[g*32 +: 32];
                    m_tags.push_back(g);
                    m_ptr = (g + 1) % N;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct { int id; logic [N-1:0] mask; logic [31:0] data; int at; } rsp_t;
    logic [N-1:0] hold_mask = '0;
    int   cyc = 0;
    int   grant_log[$];
    int   grant_cyc[$];
    rsp_t rsp_log[$];
    int   drain_rise_cyc = -1;

    // One clock: observe at the falling edge, then update requesters just after the rising edge.
    task automatic cycle();
        logic [N-1:0] acc;
        rsp_t r;
        @(negedge clk);
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
        if (rsp_valid != '0) begin
            r.id = -1;
            for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) r.id = i;
            r.mask = rsp_valid; r.data = rsp_data; r.at = cyc;
            rsp_log.push_back(r);
        end
        if (drain_done && drain_rise_cyc < 0) drain_rise_cyc = cyc;
        @(posedge clk); #1;
        cyc++;
        req_valid = req_valid & ~(acc & ~hold_mask);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_c[i*32 +: 32] = c;
        req_valid[i] = 1'b1;
    endtask

    task automatic clear_logs();
        grant_log.delete(); grant_cyc.delete(); rsp_log.delete(); drain_rise_cyc = -1;
    endtask

    task automatic do_reset();
        req_valid = '0; hold_mask = '0; stall = 1'b0; drain_req = 1'b0;
        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int k = 0; k < budget && rsp_log.size() < n; k++) cycle();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        cycle(); cycle();
        check("rst_req_ready",  32'(req_ready),    32'h0);
        check("rst_fvin",       32'(fma_valid_in), 32'h0);
        check("rst_fma_a",      fma_a,             32'h0);
        check("rst_rsp_valid",  32'(rsp_valid),    32'h0);
        check("rst_inflight",   32'(inflight),     32'h0);
        check("rst_drain_done", 32'(drain_done),   32'h0);
        rst_n = 1'b1;
        clear_logs();

        // Single request from requester 0.
        set_req(0, 32'h3FC00000, 32'h40200000, 32'h40400000);
        wait_rsp(1, 40);
        check("single_rsp_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() > 0) begin
            check("single_rsp_mask", 32'(rsp_log[0].mask), 32'b0001);
            check("single_rsp_data", rsp_log[0].data,     32'h40D80000);
        end
        cycle();
        check("single_inflight", 32'(inflight), 32'd0);

        // Contention: all four at once from rr_ptr = 0.
        do_reset();
        set_req(0, 32'h3F800000, 32'h40000000, 32'h40400000);
        set_req(1, 32'h41200000, 32'hBF000000, 32'h42C80000);
        set_req(2, 32'h40800000, 32'h40800000, 32'h3F800000);
        set_req(3, 32'hC0000000, 32'h3F000000, 32'h40A00000);
        wait_rsp(4, 40);
        check("cont_grants", 32'(grant_log.size()), 32'd4);
        check("cont_rsps",   32'(rsp_log.size()),   32'd4);
        if (grant_log.size() == 4 && rsp_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("cont_grant_order", 32'(grant_log[k]), 32'(k));
                check("cont_rsp_order",   32'(rsp_log[k].id), 32'(k));
            end
            check("cont_back_to_back", 32'(grant_cyc[3] - grant_cyc[0]), 32'd3);
            check("cont_req1_mask",    32'(rsp_log[1].mask), 32'b0010);
            check("cont_req1_data",    rsp_log[1].data,      32'h42BE0000);
        end

        // Fairness: requesters 0 and 2 held valid.
        do_reset();
        set_req(0, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        set_req(2, 32'h40000000, 32'h40000000, 32'h40000000);
        hold_mask = 4'b0101;
        for (int k = 0; k < 8; k++) cycle();
        hold_mask = '0; req_valid = '0;
        check("fair_grants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("fair_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
        wait_rsp(grant_log.size(), 40);
        check("fair_all_returned", 32'(rsp_log.size()), 32'(grant_log.size()));

        // Credit limit with the pipeline output stalled.
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'h3F800000, 32'h0);
        hold_mask = 4'hF;
        for (int k = 0; k < 14; k++) cycle();
        check("credit_grants",   32'(grant_log.size()), 32'd8);
        check("credit_ready",    32'(req_ready),        32'h0);
        check("credit_inflight", 32'(inflight),         32'd8);
        release_one = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        check("credit_one_more", 32'(grant_log.size()), 32'd9);
        if (grant_log.size() > 8) check("credit_next_id", 32'(grant_log[8]), 32'd0);
        hold_mask = '0; req_valid = '0; stall = 1'b0;
        wait_rsp(9, 60);
        check("credit_all_returned", 32'(rsp_log.size()), 32'd9);

        // Drain with three in flight, then resume.
        do_reset();
        set_req(0, 32'h3F800000, 32'h3F800000, 32'h0);
        set_req(1, 32'h40000000, 32'h3F800000, 32'h0);
        set_req(2, 32'h40400000, 32'h3F800000, 32'h0);
        for (int k = 0; k < 10 && grant_log.size() < 3; k++) cycle();
        drain_req = 1'b1;
        cycle();
        set_req(3, 32'h3E800000, 32'h3E800000, 32'h3E800000);
        for (int k = 0; k < 30 && drain_rise_cyc < 0; k++) cycle();
        check("drain_reached",   32'(drain_rise_cyc >= 0), 32'd1);
        check("drain_no_grants", 32'(grant_log.size()),    32'd3);
        check("drain_rsps",      32'(rsp_log.size()),      32'd3);
        if (rsp_log.size() == 3)
            check("drain_timing", 32'(drain_rise_cyc), 32'(rsp_log[2].at + 1));
        drain_req = 1'b0;
        wait_rsp(4, 30);
        check("resume_rsps", 32'(rsp_log.size()), 32'd4);
        if (rsp_log.size() == 4 && grant_log.size() == 4) begin
            check("resume_grant", 32'(grant_log[3]),   32'd3);
            check("resume_id",    32'(rsp_log[3].id),  32'd3);
            check("resume_data",  rsp_log[3].data,     32'h3EA00000);
        end

        // Orphan result.
        begin
            int n0;
            n0 = rsp_log.size();
            inject_orphan = 1'b1;
            for (int k = 0; k < 4; k++) cycle();
            check("orphan_flag",   32'(err_orphan),     32'd1);
            check("orphan_no_rsp", 32'(rsp_log.size()), 32'(n0));
        end

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < N; i++) set_req(i, 32'h40000000 + 32'(i), 32'h3F800000, 32'h3F800000);
        hold_mask = 4'hF;
        for (int k = 0; k < 6; k++) cycle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready",    32'(req_ready),    32'h0);
        check("mid_rst_fvin",     32'(fma_valid_in), 32'h0);
        check("mid_rst_fma_a",    fma_a,             32'h0);
        check("mid_rst_rsp",      32'(rsp_valid),    32'h0);
        check("mid_rst_rsp_data", rsp_data,          32'h0);
        check("mid_rst_inflight", 32'(inflight),     32'h0);
        check("mid_rst_orphan",   32'(err_orphan),   32'h0);
        hold_mask = '0; req_valid = '0;
        cycle(); cycle();
        rst_n = 1'b1;
        clear_logs();
        for (int k = 0; k < 10; k++) cycle();
        check("post_rst_no_rsp", 32'(rsp_log.size()), 32'd0);
        check("post_rst_orphan", 32'(err_orphan),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
